breakout_frame_scheduler: RTL

Frame scheduler for the breakout-to-host serial link. It generates frame timing for the 10-bit, two-lane DDR serializer and round-robin arbitrates four requesters for each frame slot. It builds each 20-bit frame payload with source ID, valid and parity header bits. It sits between the breakout's parallel sources (buttons, digital port, link-power status, aux) and the serializer, which loads one payload per frame.

---
 rtl/breakout_frame_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/breakout_frame_scheduler.sv
// -----------------------------------------------------------------------------
// breakout_frame_scheduler
//
// Generates frame timing for the breakout-to-host serializer (10 bits per lane,
// two DDR lanes) and round-robin arbitrates the four parallel sources for each
// frame slot. Every FRAME_CYCLES clocks one 20-bit payload is presented: either
// the granted source's word with ID/valid/parity header, or an all-zero idle
// frame so the host always sees a continuous stream.
//
// Ports
//   i_clk        serializer clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_en         grant enable (sampled at the load edge)
//   i_req        per-source request level, bit n = source n
//   i_data       per-source 16-bit words, source n at [16n+15:16n]
//   o_ack        one-hot 1-cycle capture pulse, coincident with o_load
//   o_load       1-cycle pulse: new payload on o_frame_d0/o_frame_d1
//   o_frame_d0   lane 0 payload {src_id[1:0], data[7:0]}
//   o_frame_d1   lane 1 payload {valid, parity, data[15:8]}
//   o_frame_cnt  frames issued, wraps at 255
//   o_idle_cnt   idle frames issued, saturates at 255
// -----------------------------------------------------------------------------
module breakout_frame_scheduler #(
  parameter int FRAME_CYCLES = 5,
  parameter int NUM_SRC      = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [NUM_SRC-1:0]     i_req,
  input  logic [16*NUM_SRC-1:0]  i_data,
  output logic [NUM_SRC-1:0]     o_ack,
  output logic                   o_load,
  output logic [9:0]             o_frame_d0,
  output logic [9:0]             o_frame_d1,
  output logic [7:0]             o_frame_cnt,
  output logic [7:0]             o_idle_cnt
);

  localparam int              PW         = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [PW-1:0]   LAST_PHASE = PW'(FRAME_CYCLES - 1);

  // State
  logic [PW-1:0]        phase_q,      phase_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic                 load_q,       load_d;
  logic [NUM_SRC-1:0]   ack_q,        ack_d;
  logic [9:0]           frame_d0_q,   frame_d0_d;
  logic [9:0]           frame_d1_q,   frame_d1_d;
  logic [7:0]           frame_cnt_q,  frame_cnt_d;
  logic [7:0]           idle_cnt_q,   idle_cnt_d;

  // Arbitration results
  logic [NUM_SRC-1:0]   eligible;
  logic                 grant_found;
  logic [1:0]           grant_idx;
  logic [1:0]           cand;
  logic [15:0]          grant_word;
  logic                 grant_par;
  logic                 load_cycle;

  assign load_cycle = (phase_q == LAST_PHASE);

  // Round-robin search: candidates last_grant+1 .. last_grant+4 (mod 4), so the
  // previous winner is considered last and only wins when nobody else is eligible.
  // NOTE: every combinational output gets a default at the top of the block so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    eligible    = i_req & {NUM_SRC{i_en}};
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = last_grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_word = i_data[{grant_idx, 4'h0} +: 16];
    grant_par  = ^{grant_idx, grant_word};
  end

  // Next-state: everything except the phase only moves on the load edge.
  always_comb begin
    phase_d      = load_cycle ? '0 : phase_q + PW'(1);
    last_grant_d = last_grant_q;
    load_d       = 1'b0;
    ack_d        = '0;
    frame_d0_d   = frame_d0_q;
    frame_d1_d   = frame_d1_q;
    frame_cnt_d  = frame_cnt_q;
    idle_cnt_d   = idle_cnt_q;

    if (load_cycle) begin
      load_d      = 1'b1;
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (grant_found) begin
        ack_d[grant_idx] = 1'b1;
        last_grant_d     = grant_idx;
        frame_d0_d       = {grant_idx, grant_word[7:0]};
        frame_d1_d       = {1'b1, grant_par, grant_word[15:8]};
      end else begin
        frame_d0_d = 10'h000;
        frame_d1_d = 10'h000;
        idle_cnt_d = (idle_cnt_q == 8'hFF) ? idle_cnt_q : idle_cnt_q + 8'd1;
      end
    end
  end

  // last_grant resets to 3 so source 0 is first in line after reset.
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      phase_q      <= '0;
      last_grant_q <= 2'd3;
      load_q       <= 1'b0;
      ack_q        <= '0;
      frame_d0_q   <= '0;
      frame_d1_q   <= '0;
      frame_cnt_q  <= '0;
      idle_cnt_q   <= '0;
    end else begin
      phase_q      <= phase_d;
      last_grant_q <= last_grant_d;
      load_q       <= load_d;
      ack_q        <= ack_d;
      frame_d0_q   <= frame_d0_d;
      frame_d1_q   <= frame_d1_d;
      frame_cnt_q  <= frame_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign o_ack       = ack_q;
  assign o_load      = load_q;
  assign o_frame_d0  = frame_d0_q;
  assign o_frame_d1  = frame_d1_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_idle_cnt  = idle_cnt_q;

endmodule
